// File: rtl/seq_alu.sv
// seq_alu: valid/ready ALU with an accumulator operand, shifts and result/flag registers.
// Define SEQ_ALU_MUL_EN to build opcode 11 as a shift-add multiplier; without it opcode 11 is illegal.
module seq_alu #(
    parameter int WIDTH = 4,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic             in_acc,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero,
    output logic             out_err
);

    // state | meaning
    // IDLE  | no result held, ready for a request
    // BUSY  | multiplier iterating, request inputs ignored
    // DONE  | result registers hold an unconsumed result
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             err_q, err_d;
    logic             valid_q, valid_d;

    logic             accept;
    logic [WIDTH-1:0] op_a;
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   sum_add;
    logic [WIDTH:0]   sum_sub;
    logic [WIDTH-1:0] alu_res;
    logic             alu_cout;
    logic             alu_ovf;
    logic             alu_err;

`ifdef SEQ_ALU_MUL_EN
    localparam int         CW     = $clog2(WIDTH + 1);
    localparam logic [3:0] OP_MUL = 4'd11;

    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_step;
`endif

    assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = valid_q;
    assign out_res   = res_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;
    assign out_zero  = zero_q;
    assign out_err   = err_q;

    // Accumulator already holds the result being consumed when a request lands in DONE.
    always_comb begin
        op_a     = in_acc ? acc_q : in_a;
        shamt    = in_b[SHW-1:0];
        sum_add  = {1'b0, op_a} + {1'b0, in_b};
        sum_sub  = {1'b0, op_a} + {1'b0, ~in_b} + {{WIDTH{1'b0}}, 1'b1};
        alu_res  = '0;
        alu_cout = 1'b0;
        alu_ovf  = 1'b0;
        alu_err  = 1'b0;
        case (in_op)
            4'd0: begin
                alu_res  = sum_add[WIDTH-1:0];
                alu_cout = sum_add[WIDTH];
                alu_ovf  = (op_a[WIDTH-1] == in_b[WIDTH-1]) && (sum_add[WIDTH-1] != op_a[WIDTH-1]);
            end
            4'd1: begin
                alu_res  = sum_sub[WIDTH-1:0];
                alu_cout = sum_sub[WIDTH];
                alu_ovf  = (op_a[WIDTH-1] != in_b[WIDTH-1]) && (sum_sub[WIDTH-1] != op_a[WIDTH-1]);
            end
            4'd2:  alu_res = ~op_a;
            4'd3:  alu_res = op_a & in_b;
            4'd4:  alu_res = op_a | in_b;
            4'd5:  alu_res = op_a ^ in_b;
            4'd6:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(in_b))};
            4'd7:  alu_res = {{(WIDTH-1){1'b0}}, (op_a == in_b)};
            4'd8:  alu_res = op_a << shamt;
            4'd9:  alu_res = op_a >> shamt;
            4'd10: alu_res = $signed(op_a) >>> shamt;
            default: alu_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        res_d   = res_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        err_d   = err_q;
        valid_d = valid_q;
`ifdef SEQ_ALU_MUL_EN
        prod_d    = prod_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);

        if (accept && (in_op == OP_MUL)) begin
            state_d  = S_BUSY;
            valid_d  = 1'b0;
            prod_d   = '0;
            mcand_d  = {{WIDTH{1'b0}}, op_a};
            mplier_d = in_b;
            cnt_d    = CW'(WIDTH);
        end else
`endif
        if (accept) begin
            state_d = S_DONE;
            valid_d = 1'b1;
            res_d   = alu_res;
            cout_d  = alu_cout;
            ovf_d   = alu_ovf;
            zero_d  = (alu_res == '0);
            err_d   = alu_err;
            acc_d   = alu_res;
        end else begin
            case (state_q)
                S_DONE: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                        valid_d = 1'b0;
                    end
                end
`ifdef SEQ_ALU_MUL_EN
                // Last partial product folds straight into the result registers.
                S_BUSY: begin
                    prod_d   = prod_step;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_d = S_DONE;
                        valid_d = 1'b1;
                        res_d   = prod_step[WIDTH-1:0];
                        cout_d  = |prod_step[2*WIDTH-1:WIDTH];
                        ovf_d   = 1'b0;
                        zero_d  = (prod_step[WIDTH-1:0] == '0);
                        err_d   = 1'b0;
                        acc_d   = prod_step[WIDTH-1:0];
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            res_q    <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            prod_q   <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            res_q    <= res_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
`ifdef SEQ_ALU_MUL_EN
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed and randomized checks of seq_alu against an arithmetic reference model.
// Honours SEQ_ALU_MUL_EN the same way the design does.
module tb_seq_alu;

    localparam int W   = 4;
    localparam int M   = 1 << W;
    localparam int SHM = (1 << $clog2(W)) - 1;
`ifdef SEQ_ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   in_op = 4'd0;
    logic         in_acc = 1'b0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_res;
    logic         out_cout;
    logic         out_ovf;
    logic         out_zero;
    logic         out_err;

    int n_cmp = 0;
    int n_mis = 0;
    int m_acc = 0;

    typedef struct {
        int res;
        int cout;
        int ovf;
        int zero;
        int err;
    } exp_t;

    seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_acc(in_acc),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
        .out_cout(out_cout), .out_ovf(out_ovf), .out_zero(out_zero), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int sx(input int v);
        return (v >= M / 2) ? v - M : v;
    endfunction

    function automatic int oob(input int v);
        return ((v > M / 2 - 1) || (v < -(M / 2))) ? 1 : 0;
    endfunction

    function automatic exp_t model(input int op, input int a, input int b);
        exp_t e;
        int   sh;
        int   p;
        sh = b & SHM;
        e.res = 0; e.cout = 0; e.ovf = 0; e.err = 0;
        case (op)
            0: begin
                e.res = (a + b) % M; e.cout = (a + b >= M) ? 1 : 0; e.ovf = oob(sx(a) + sx(b));
            end
            1: begin
                e.res = (a - b + M) % M; e.cout = (a >= b) ? 1 : 0; e.ovf = oob(sx(a) - sx(b));
            end
            2:  e.res = M - 1 - a;
            3:  e.res = a & b;
            4:  e.res = a | b;
            5:  e.res = a ^ b;
            6:  e.res = (sx(a) < sx(b)) ? 1 : 0;
            7:  e.res = (a == b) ? 1 : 0;
            8:  e.res = (a << sh) % M;
            9:  e.res = a >> sh;
            10: e.res = (sx(a) >>> sh) & (M - 1);
            11: begin
                if (MUL_EN) begin
                    p = a * b; e.res = p % M; e.cout = (p >= M) ? 1 : 0;
                end else begin
                    e.err = 1;
                end
            end
            default: e.err = 1;
        endcase
        e.zero = (e.res == 0) ? 1 : 0;
        return e;
    endfunction

    task automatic check_outputs(input string tag, input exp_t e);
        chk({tag, "_res"},  int'(out_res),  e.res);
        chk({tag, "_cout"}, int'(out_cout), e.cout);
        chk({tag, "_ovf"},  int'(out_ovf),  e.ovf);
        chk({tag, "_zero"}, int'(out_zero), e.zero);
        chk({tag, "_err"},  int'(out_err),  e.err);
    endtask

    // One full transaction from IDLE: accept, wait for result, optional stall, consume.
    task automatic run_op(input string tag, input int op, input int use_acc, input int a, input int b,
                          input int stall);
        exp_t e;
        int   lat;
        int   exp_lat;
        bit   got;
        e       = model(op, (use_acc != 0) ? m_acc : a, b);
        exp_lat = (MUL_EN && op == 11) ? W + 1 : 1;
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 4'(op);
        in_acc   = (use_acc != 0);
        in_a     = (use_acc != 0) ? W'($urandom_range(0, M - 1)) : W'(a);
        in_b     = W'(b);
        chk({tag, "_rdy"}, int'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_a     = W'($urandom_range(0, M - 1));
        in_b     = W'($urandom_range(0, M - 1));
        lat = 1;
        got = 1'b0;
        while (!got) begin
            @(negedge clk);
            if (out_valid || lat > 20) begin
                got = 1'b1;
            end else begin
                chk({tag, "_busy_rdy"}, int'(in_ready), 0);
                @(posedge clk);
                lat++;
            end
        end
        chk({tag, "_lat"}, lat, exp_lat);
        check_outputs(tag, e);
        m_acc = e.res;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_hold_res"},   int'(out_res),   e.res);
            chk({tag, "_hold_valid"}, int'(out_valid), 1);
            chk({tag, "_hold_rdy"},   int'(in_ready),  0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_drained"}, int'(out_valid), 0);
    endtask

    initial begin
        exp_t e;
        #3;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_res",   int'(out_res),   0);
        chk("rst_flags", int'({out_cout, out_ovf, out_zero, out_err}), 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_in_ready", int'(in_ready), 1);

        run_op("add_7_9",  0, 0, 7, 9, 0);
        run_op("add_7_1",  0, 0, 7, 1, 0);
        run_op("sub_8_1",  1, 0, 8, 1, 0);
        run_op("slt_f_1",  6, 0, 15, 1, 0);
        chk("slt_f_1_direct", int'(out_res), 1);
        run_op("sra_8_2", 10, 0, 8, 2, 0);
        chk("sra_8_2_direct", int'(out_res), 14);
        run_op("eq_5_5",   7, 0, 5, 5, 0);
        run_op("mul_6_7", 11, 0, 6, 7, 1);
        run_op("illegal", 13, 0, 3, 3, 0);

        // Back-to-back with the consumer always ready, second request rides the DONE cycle.
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_op     = 4'd0;
        in_acc    = 1'b0;
        in_a      = W'(3);
        in_b      = W'(2);
        @(posedge clk);
        #1;
        in_acc = 1'b1;
        in_a   = W'(15);
        in_b   = W'(4);
        @(negedge clk);
        chk("b2b_first_valid", int'(out_valid), 1);
        chk("b2b_first_res",   int'(out_res),   5);
        chk("b2b_first_rdy",   int'(in_ready),  1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("b2b_second_valid", int'(out_valid), 1);
        chk("b2b_second_res",   int'(out_res),   9);
        m_acc = 9;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("b2b_hold_res", int'(out_res),  9);
            chk("b2b_hold_rdy", int'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Reset in the middle of a multiply (or in DONE when the multiplier is absent).
        @(negedge clk);
        in_valid = 1'b1;
        in_op    = 4'd11;
        in_acc   = 1'b0;
        in_a     = W'(6);
        in_b     = W'(7);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("abort_valid", int'(out_valid), 0);
        chk("abort_res",   int'(out_res),   0);
        chk("abort_flags", int'({out_cout, out_ovf, out_zero, out_err}), 0);
        m_acc = 0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_in_ready", int'(in_ready), 1);
        run_op("post_rst_acc", 0, 1, 0, 3, 0);
        run_op("post_rst_add", 0, 0, 1, 1, 0);
        run_op("acc_readback", 0, 1, 0, 0, 0);

        for (int i = 0; i < 150; i++) begin
            run_op("rand", int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
                   int'($urandom_range(0, M - 1)), int'($urandom_range(0, M - 1)),
                   int'($urandom_range(0, 2)));
        end
        e = model(11, 15, 15);
        run_op("mul_max", 11, 0, 15, 15, 0);
        chk("mul_max_direct", int'(out_res), e.res);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
